// File: rtl/jk_bank_ctrl.sv
// ---------------------------------------------------------------------------
// jk_bank_ctrl
// Sequencer for a bank of WIDTH JK flip-flops. It accepts one command at a
// time, turns it into per-bit J/K drive vectors with an update enable, and
// reads the bank's registered outputs back as feedback for counting.
//
// Ports
//   clk        rising-edge clock shared with the JK bank
//   reset_n    asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (IDLE only)
//   cmd_op     0 NOP, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 CNT_UP,
//              6 CNT_DOWN, 7 reserved (acts as NOP)
//   cmd_data   LOAD value or TOGGLE mask
//   cmd_steps  number of count steps for CNT_UP / CNT_DOWN
//   abort      stops an in-progress count after the current step
//   q_fb       registered q outputs of the JK bank
//   jk_j/jk_k  J and K drive per bit (zero whenever jk_en is low)
//   jk_en      bank updates on the next rising edge when high
//   busy       controller is not IDLE
//   done       one-cycle completion pulse
//   wrapped    with done: a count crossed all-ones<->zero
//   aborted    with done: the count was cut short by abort
// ---------------------------------------------------------------------------
module jk_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             jk_en,
    output logic             busy,
    output logic             done,
    output logic             wrapped,
    output logic             aborted
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_CNT_UP = 3'd5;
    localparam logic [2:0] OP_CNT_DN = 3'd6;

    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZEROS = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] STEP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] STEP_ZERO = {CNT_W{1'b0}};

    // Value a JK bank takes after one enabled edge with the given drive.
    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k);
        logic [WIDTH-1:0] r;
        r = q;
        for (int i = 0; i < WIDTH; i++) begin
            case ({j[i], k[i]})
                2'b00:   r[i] = q[i];
                2'b01:   r[i] = 1'b0;
                2'b10:   r[i] = 1'b1;
                2'b11:   r[i] = ~q[i];
                default: r[i] = q[i];
            endcase
        end
        return r;
    endfunction

    // Bits to toggle for one synchronous count step: bit i toggles when all
    // lower bits are 1 (up) or all 0 (down); bit 0 always toggles.
    function automatic logic [WIDTH-1:0] count_mask(input logic [WIDTH-1:0] q,
                                                    input logic up);
        logic [WIDTH-1:0] m;
        logic             run;
        m   = ALL_ZEROS;
        run = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = run;
            run  = run & (up ? q[i] : ~q[i]);
        end
        return m;
    endfunction

    // A step taken from this value crosses the wrap boundary.
    function automatic logic at_wrap(input logic [WIDTH-1:0] q, input logic up);
        return up ? (q == ALL_ONES) : (q == ALL_ZEROS);
    endfunction

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] steps_q,   steps_d;
    logic             dir_up_q,  dir_up_d;
    logic [WIDTH-1:0] jk_j_q,    jk_j_d;
    logic [WIDTH-1:0] jk_k_q,    jk_k_d;
    logic             jk_en_q,   jk_en_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             wrapped_q, wrapped_d;
    logic             aborted_q, aborted_d;
    logic             ready_q,   ready_d;

    logic [WIDTH-1:0] q_pred_s;
    logic [WIDTH-1:0] step_mask_s;
    logic             step_wrap_s;
    logic             step_up_s;

    // The drive is registered, so the next step must be computed from the
    // value the bank will hold after the edge that applies the current drive.
    always_comb begin
        if (jk_en_q) begin
            q_pred_s = jk_next(q_fb, jk_j_q, jk_k_q);
        end else begin
            q_pred_s = q_fb;
        end
        if (state_q == ST_IDLE) begin
            step_up_s = (cmd_op == OP_CNT_UP);
        end else begin
            step_up_s = dir_up_q;
        end
        step_mask_s = count_mask(q_pred_s, step_up_s);
        step_wrap_s = at_wrap(q_pred_s, step_up_s);
    end

    // Next-state and next-output logic for the command sequencer.
    always_comb begin
        state_d   = state_q;
        steps_d   = steps_q;
        dir_up_d  = dir_up_q;
        jk_j_d    = ALL_ZEROS;
        jk_k_d    = ALL_ZEROS;
        jk_en_d   = 1'b0;
        wrapped_d = wrapped_q;
        aborted_d = aborted_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    wrapped_d = 1'b0;
                    aborted_d = 1'b0;
                    dir_up_d  = step_up_s;
                    case (cmd_op)
                        OP_CLEAR: begin
                            state_d = ST_APPLY;
                            jk_en_d = 1'b1;
                            jk_k_d  = ALL_ONES;
                        end
                        OP_SET: begin
                            state_d = ST_APPLY;
                            jk_en_d = 1'b1;
                            jk_j_d  = ALL_ONES;
                        end
                        OP_LOAD: begin
                            state_d = ST_APPLY;
                            jk_en_d = 1'b1;
                            jk_j_d  = cmd_data;
                            jk_k_d  = ~cmd_data;
                        end
                        OP_TOGGLE: begin
                            state_d = ST_APPLY;
                            jk_en_d = 1'b1;
                            jk_j_d  = cmd_data;
                            jk_k_d  = cmd_data;
                        end
                        OP_CNT_UP, OP_CNT_DN: begin
                            if (cmd_steps == STEP_ZERO) begin
                                state_d = ST_DONE;
                            end else begin
                                // First step is driven straight out of IDLE.
                                state_d   = ST_COUNT;
                                jk_en_d   = 1'b1;
                                jk_j_d    = step_mask_s;
                                jk_k_d    = step_mask_s;
                                steps_d   = cmd_steps - STEP_ONE;
                                wrapped_d = step_wrap_s;
                            end
                        end
                        default: begin
                            state_d = ST_DONE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                state_d = ST_DONE;
            end
            ST_COUNT: begin
                // steps_q counts steps still to issue after the one on the bus.
                if (abort || (steps_q == STEP_ZERO)) begin
                    state_d   = ST_DONE;
                    aborted_d = abort;
                end else begin
                    jk_en_d   = 1'b1;
                    jk_j_d    = step_mask_s;
                    jk_k_d    = step_mask_s;
                    steps_d   = steps_q - STEP_ONE;
                    wrapped_d = wrapped_q | step_wrap_s;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs follow the next state so they are registered together.
    always_comb begin
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset leaves the controller idle and ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            steps_q   <= STEP_ZERO;
            dir_up_q  <= 1'b0;
            jk_j_q    <= ALL_ZEROS;
            jk_k_q    <= ALL_ZEROS;
            jk_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrapped_q <= 1'b0;
            aborted_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            steps_q   <= steps_d;
            dir_up_q  <= dir_up_d;
            jk_j_q    <= jk_j_d;
            jk_k_q    <= jk_k_d;
            jk_en_q   <= jk_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wrapped_q <= wrapped_d;
            aborted_q <= aborted_d;
            ready_q   <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign jk_j      = jk_j_q;
    assign jk_k      = jk_k_q;
    assign jk_en     = jk_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrapped   = wrapped_q;
    assign aborted   = aborted_q;

endmodule
